sram_burst_model: RTL and testbench

Parametrised, synthesisable successor to the team's fixed 32-bit/64-bit behavioural SRAM model. It provides a word-addressed memory with aligned burst reads, byte-strobed single-word writes and a configurable read latency counted in clock cycles. A valid/ready request handshake replaces the time-delayed bidirectional bus. It sits between the memory-stage SRAM controller and the board-level memory, and also serves as the testbench memory.

---
 rtl/sram_burst_model_if.sv | 27 ++
 rtl/sram_burst_model.sv | 117 +++++++++++
 tb/tb_sram_burst_model.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_burst_model_if.sv
// Request/response bus of sram_burst_model: valid/ready requests in, strobed burst responses out.
interface sram_burst_model_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 17,
  parameter int BURST  = 2
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [ADDR_W-1:0]       req_addr;
  logic [DATA_W-1:0]       req_wdata;
  logic [DATA_W/8-1:0]     req_wstrb;
  logic                    rsp_valid;
  logic [BURST*DATA_W-1:0] rsp_data;
  logic                    rsp_err;
  logic                    wr_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_data, rsp_err, wr_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_data, rsp_err, wr_err
  );
endinterface

// File: rtl/sram_burst_model.sv
// Word-addressed SRAM with aligned burst reads, byte-strobed writes and a fixed read latency.
module sram_burst_model #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 17,
  parameter int DEPTH    = 512,
  parameter int BURST    = 2,
  parameter int READ_LAT = 3
) (
  input logic               clk,
  input logic               reset,
  sram_burst_model_if.slave bus
);
  // state | meaning
  // IDLE  | ready for any request
  // WAIT  | read accepted, latency counter running, requests stalled
  // RESP  | one-cycle read response; a new request may be accepted
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BURST - 1);
  localparam logic [ADDR_W:0]   DEPTH_A    = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(READ_LAT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0]       base_q, base_d;
  logic [BURST*DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    wr_err_q, wr_err_d;
  logic [DATA_W-1:0]       mem_q [DEPTH];

  logic                    accept, rd_acc, wr_acc, wr_en, rd_in_range;
  logic [BURST*DATA_W-1:0] rd_burst;

  always_ff @(posedge clk or negedge reset) begin : state_reg
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      base_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      base_q     <= base_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      wr_err_q   <= wr_err_d;
    end
  end

  always_comb begin : decode
    accept   = bus.req_valid && (state_q != S_WAIT);
    rd_acc   = accept && !bus.req_we;
    wr_acc   = accept && bus.req_we;
    wr_en    = wr_acc && ({1'b0, bus.req_addr} < DEPTH_A);
    wr_err_d = wr_acc && !wr_en;
    base_d   = rd_acc ? (bus.req_addr & ALIGN_MASK) : base_q;
  end

  always_comb begin : next_state
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = S_RESP;
      end
      default: begin
        state_d = S_IDLE;
        if (rd_acc) begin
          if (READ_LAT == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
    endcase
  end

  // Memory cannot change while a read waits, so loading on entry to RESP equals the accept-time snapshot.
  always_comb begin : response
    rd_burst    = '0;
    rd_in_range = ({1'b0, base_d} < DEPTH_A);
    for (int k = 0; k < BURST; k++) begin
      rd_burst[k*DATA_W +: DATA_W] = mem_q[IDX_W'(base_d[IDX_W-1:0] + IDX_W'(k))];
    end
    rsp_data_d = rsp_data_q;
    rsp_err_d  = 1'b0;
    if (state_d == S_RESP) begin
      rsp_data_d = rd_in_range ? rd_burst : '0;
      rsp_err_d  = !rd_in_range;
    end
  end

  always_comb begin : outputs
    bus.req_ready = (state_q != S_WAIT);
    bus.rsp_valid = (state_q == S_RESP);
    bus.rsp_data  = rsp_data_q;
    bus.rsp_err   = rsp_err_q;
    bus.wr_err    = wr_err_q;
  end

  always_ff @(posedge clk) begin : mem_write
    if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (bus.req_wstrb[b]) mem_q[IDX_W'(bus.req_addr)][b*8 +: 8] <= bus.req_wdata[b*8 +: 8];
      end
    end
  end
endmodule

// File: tb/tb_sram_burst_model.sv
// Randomized self-checking bench for sram_burst_model against an array-based memory model.
`timescale 1ns/1ps
module tb_sram_burst_model;
  localparam int DEP = 512;
  localparam int BR  = 2;
  localparam int LAT = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] mm [DEP];
  logic [31:0] m1 [16];
  logic [15:0] mc [16];

  always #5 clk = ~clk;

  sram_burst_model_if #(.DATA_W(32), .ADDR_W(17), .BURST(2)) bm ();
  sram_burst_model_if #(.DATA_W(32), .ADDR_W(17), .BURST(2)) b1 ();
  sram_burst_model_if #(.DATA_W(16), .ADDR_W(17), .BURST(4)) bc ();

  sram_burst_model #(.DATA_W(32), .ADDR_W(17), .DEPTH(512), .BURST(2), .READ_LAT(3)) dut_m (
    .clk(clk), .reset(reset), .bus(bm.slave));
  sram_burst_model #(.DATA_W(32), .ADDR_W(17), .DEPTH(512), .BURST(2), .READ_LAT(1)) dut_1 (
    .clk(clk), .reset(reset), .bus(b1.slave));
  sram_burst_model #(.DATA_W(16), .ADDR_W(17), .DEPTH(512), .BURST(4), .READ_LAT(5)) dut_c (
    .clk(clk), .reset(reset), .bus(bc.slave));

  function automatic int base_of(input logic [16:0] a);
    return (int'(a) / BR) * BR;
  endfunction

  function automatic logic exp_err(input logic [16:0] a);
    return base_of(a) >= DEP;
  endfunction

  function automatic logic [63:0] exp_rd(input logic [16:0] a);
    int b;
    b = base_of(a);
    if (b >= DEP) return 64'd0;
    return {mm[b+1], mm[b]};
  endfunction

  task automatic all_idle();
    bm.req_valid = 0; bm.req_we = 0; bm.req_addr = '0; bm.req_wdata = '0; bm.req_wstrb = '0;
    b1.req_valid = 0; b1.req_we = 0; b1.req_addr = '0; b1.req_wdata = '0; b1.req_wstrb = '0;
    bc.req_valid = 0; bc.req_we = 0; bc.req_addr = '0; bc.req_wdata = '0; bc.req_wstrb = '0;
  endtask

  // Called at a negedge with req_ready high; returns at the negedge after the accepting edge.
  task automatic m_write(input logic [16:0] a, input logic [31:0] d, input logic [3:0] s);
    bm.req_valid = 1; bm.req_we = 1; bm.req_addr = a; bm.req_wdata = d; bm.req_wstrb = s;
    @(negedge clk);
    bm.req_valid = 0; bm.req_we = 0;
    if (int'(a) < DEP)
      for (int b = 0; b < 4; b++) if (s[b]) mm[int'(a)][b*8 +: 8] = d[b*8 +: 8];
  endtask

  // Returns in the response cycle; lat = -1 if no response within the bound.
  task automatic m_read(input logic [16:0] a, output int lat, output int low,
                        output logic [63:0] d, output logic e);
    bm.req_valid = 1; bm.req_we = 0; bm.req_addr = a;
    lat = -1; low = 0; d = '0; e = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) bm.req_valid = 0;
      if (!bm.req_ready) low++;
      if (bm.rsp_valid) begin
        lat = c; d = bm.rsp_data; e = bm.rsp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 0;
    for (int i = 0; i < 6; i++) begin
      bm.req_valid = 1'($urandom); bm.req_we = 1'($urandom); bm.req_addr = 17'($urandom);
      bm.req_wdata = $urandom; bm.req_wstrb = 4'($urandom);
      b1.req_valid = 1'($urandom); b1.req_we = 1'($urandom); b1.req_addr = 17'($urandom);
      b1.req_wdata = $urandom; b1.req_wstrb = 4'($urandom);
      bc.req_valid = 1'($urandom); bc.req_we = 1'($urandom); bc.req_addr = 17'($urandom);
      bc.req_wdata = 16'($urandom); bc.req_wstrb = 2'($urandom);
      @(negedge clk);
      checks++;
      if ({bm.req_ready, bm.rsp_valid, bm.rsp_err, bm.wr_err} !== 4'b1000 || bm.rsp_data !== 64'd0) begin
        errors++;
        $display("FAIL reset_hold: ready/valid/err/wr_err=%b data=%h want 1000 / 0",
                 {bm.req_ready, bm.rsp_valid, bm.rsp_err, bm.wr_err}, bm.rsp_data);
      end
    end
    all_idle();
    reset = 1;
    @(negedge clk);
    checks++;
    if ({bm.req_ready, bm.rsp_valid, bm.rsp_err, bm.wr_err} !== 4'b1000 || bm.rsp_data !== 64'd0) begin
      errors++;
      $display("FAIL reset_release: ready/valid/err/wr_err=%b data=%h want 1000 / 0",
               {bm.req_ready, bm.rsp_valid, bm.rsp_err, bm.wr_err}, bm.rsp_data);
    end
    checks++;
    if ({b1.req_ready, b1.rsp_valid, bc.req_ready, bc.rsp_valid} !== 4'b1010) begin
      errors++;
      $display("FAIL reset_variants: got %b want 1010",
               {b1.req_ready, b1.rsp_valid, bc.req_ready, bc.rsp_valid});
    end
  endtask

  task automatic test_fill();
    int bad;
    bad = 0;
    for (int a = 0; a < DEP; a++) begin
      m_write(17'(a), $urandom, 4'hF);
      if (bm.req_ready !== 1'b1 || bm.wr_err !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL fill_back_to_back: %0d cycles with ready!=1 or wr_err!=0, want 0", bad);
    end
  endtask

  task automatic test_write_read();
    int lat, low;
    logic [63:0] d;
    logic e;
    m_write(17'd4, 32'hDEADBEEF, 4'hF);
    m_write(17'd5, 32'h12345678, 4'hF);
    m_read(17'd5, lat, low, d, e);
    checks++;
    if (lat !== LAT || low !== LAT - 1) begin
      errors++;
      $display("FAIL wr_rd_latency: lat=%0d ready_low=%0d want %0d/%0d", lat, low, LAT, LAT - 1);
    end
    checks++;
    if (d !== 64'h12345678_DEADBEEF || e !== 1'b0) begin
      errors++;
      $display("FAIL wr_rd_data: data=%h err=%b want 12345678deadbeef/0", d, e);
    end
    @(negedge clk);
    checks++;
    if (bm.rsp_valid !== 1'b0 || bm.rsp_data !== 64'h12345678_DEADBEEF) begin
      errors++;
      $display("FAIL wr_rd_hold: valid=%b data=%h want 0/12345678deadbeef", bm.rsp_valid, bm.rsp_data);
    end
  endtask

  task automatic test_strobes();
    int lat, low;
    logic [63:0] d;
    logic e;
    m_write(17'd8, 32'hAABBCCDD, 4'hF);
    m_write(17'd8, 32'h11223344, 4'b0101);
    m_read(17'd8, lat, low, d, e);
    checks++;
    if (d[31:0] !== 32'hAA22CC44 || d !== exp_rd(17'd8)) begin
      errors++;
      $display("FAIL strobe_merge: data=%h want word0 aa22cc44 full %h", d, exp_rd(17'd8));
    end
    m_write(17'd9, $urandom, 4'h0);
    m_read(17'd9, lat, low, d, e);
    checks++;
    if (d !== exp_rd(17'd9)) begin
      errors++;
      $display("FAIL strobe_zero: data=%h want %h", d, exp_rd(17'd9));
    end
  endtask

  task automatic test_out_of_range();
    int lat, low;
    logic [63:0] d;
    logic e;
    m_write(17'd600, $urandom, 4'hF);
    checks++;
    if (bm.wr_err !== 1'b1) begin
      errors++;
      $display("FAIL wr_err_pulse: wr_err=%b want 1", bm.wr_err);
    end
    @(negedge clk);
    checks++;
    if (bm.wr_err !== 1'b0) begin
      errors++;
      $display("FAIL wr_err_clear: wr_err=%b want 0", bm.wr_err);
    end
    m_read(17'd88, lat, low, d, e);
    checks++;
    if (d !== exp_rd(17'd88)) begin
      errors++;
      $display("FAIL wr_oor_alias: data=%h want %h", d, exp_rd(17'd88));
    end
    m_read(17'd511, lat, low, d, e);
    checks++;
    if (lat !== LAT || e !== 1'b0 || d !== exp_rd(17'd511)) begin
      errors++;
      $display("FAIL rd_511: lat=%0d err=%b data=%h want %0d/0/%h", lat, e, d, LAT, exp_rd(17'd511));
    end
    @(negedge clk);
    checks++;
    if (bm.rsp_valid !== 1'b0 || bm.rsp_data !== exp_rd(17'd511)) begin
      errors++;
      $display("FAIL rd_hold: valid=%b data=%h want 0/%h", bm.rsp_valid, bm.rsp_data, exp_rd(17'd511));
    end
    m_read(17'd512, lat, low, d, e);
    checks++;
    if (lat !== LAT || e !== 1'b1 || d !== 64'd0) begin
      errors++;
      $display("FAIL rd_512: lat=%0d err=%b data=%h want %0d/1/0", lat, e, d, LAT);
    end
    @(negedge clk);
    checks++;
    if (bm.rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL rsp_err_clear: err=%b want 0", bm.rsp_err);
    end
    m_read(17'h10004, lat, low, d, e);
    checks++;
    if (e !== 1'b1 || d !== 64'd0) begin
      errors++;
      $display("FAIL rd_high_addr: err=%b data=%h want 1/0", e, d);
    end
  endtask

  task automatic test_reset_mid_read();
    int lat, low;
    logic [63:0] d;
    logic e;
    int seen;
    @(negedge clk);
    bm.req_valid = 1; bm.req_we = 0; bm.req_addr = 17'd20;
    @(negedge clk);
    bm.req_valid = 0;
    checks++;
    if (bm.req_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_read_wait: ready=%b want 0", bm.req_ready);
    end
    reset = 0;
    @(negedge clk);
    reset = 1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bm.rsp_valid) seen++;
    end
    checks++;
    if (seen != 0 || bm.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_read_abort: rsp_valid cycles=%0d ready=%b want 0/1", seen, bm.req_ready);
    end
    m_read(17'd20, lat, low, d, e);
    checks++;
    if (d !== exp_rd(17'd20) || e !== 1'b0) begin
      errors++;
      $display("FAIL mid_read_mem: data=%h err=%b want %h/0", d, e, exp_rd(17'd20));
    end
  endtask

  task automatic test_back_to_back();
    logic [16:0] addr [6];
    logic [63:0] old, d;
    int lat, low;
    logic e;
    for (int i = 0; i < 6; i++) addr[i] = 17'($urandom_range(0, DEP - 1));
    bm.req_valid = 1; bm.req_we = 0; bm.req_addr = addr[0];
    for (int i = 0; i < 6; i++) begin
      lat = -1;
      for (int c = 1; c <= 20; c++) begin
        @(negedge clk);
        if (c == 1) bm.req_valid = 0;
        if (bm.rsp_valid) begin
          lat = c;
          break;
        end
      end
      checks++;
      if (lat !== LAT || bm.rsp_data !== exp_rd(addr[i]) || bm.rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL b2b_read%0d: lat=%0d data=%h err=%b want %0d/%h/0",
                 i, lat, bm.rsp_data, bm.rsp_err, LAT, exp_rd(addr[i]));
      end
      if (i < 5) begin
        bm.req_valid = 1; bm.req_addr = addr[i+1];
      end
    end
    old = exp_rd(addr[5]);
    m_write(17'(base_of(addr[5])), ~old[31:0], 4'hF);
    checks++;
    if (bm.rsp_data !== old) begin
      errors++;
      $display("FAIL resp_write_hold: data=%h want %h", bm.rsp_data, old);
    end
    m_read(addr[5], lat, low, d, e);
    checks++;
    if (d !== exp_rd(addr[5])) begin
      errors++;
      $display("FAIL resp_write_visible: data=%h want %h", d, exp_rd(addr[5]));
    end
  endtask

  task automatic test_random();
    int lat, low, pick, bad;
    logic [63:0] d;
    logic e;
    logic [16:0] a;
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      pick = int'($urandom_range(0, 9));
      if (pick == 0) a = 17'($urandom);
      else if (pick == 1) a = 17'($urandom_range(500, 620));
      else a = 17'($urandom_range(0, DEP - 1));
      if ($urandom_range(0, 1) == 0) begin
        m_write(a, $urandom, 4'($urandom));
        checks++;
        if (bm.wr_err !== (int'(a) >= DEP)) begin
          errors++; bad++;
          if (bad < 5) $display("FAIL rand_wr_err: addr=%0d wr_err=%b want %b", a, bm.wr_err, int'(a) >= DEP);
        end
      end else begin
        m_read(a, lat, low, d, e);
        checks++;
        if (lat !== LAT || d !== exp_rd(a) || e !== exp_err(a)) begin
          errors++; bad++;
          if (bad < 5) $display("FAIL rand_read: addr=%0d lat=%0d data=%h err=%b want %0d/%h/%b",
                                a, lat, d, e, LAT, exp_rd(a), exp_err(a));
        end
      end
    end
  endtask

  task automatic test_lat1();
    logic [16:0] a;
    logic [63:0] want;
    for (int i = 0; i < 16; i++) begin
      m1[i] = $urandom;
      b1.req_valid = 1; b1.req_we = 1; b1.req_addr = 17'(i); b1.req_wdata = m1[i]; b1.req_wstrb = 4'hF;
      @(negedge clk);
    end
    b1.req_we = 0; b1.req_addr = 17'd1;
    for (int i = 0; i < 8; i++) begin
      a = b1.req_addr;
      @(negedge clk);
      want = {m1[(int'(a) / 2) * 2 + 1], m1[(int'(a) / 2) * 2]};
      checks++;
      if (b1.rsp_valid !== 1'b1 || b1.rsp_data !== want || b1.rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL lat1_read%0d: valid=%b data=%h err=%b want 1/%h/0", i, b1.rsp_valid, b1.rsp_data, b1.rsp_err, want);
      end
      if (i < 7) b1.req_addr = 17'(2 * (i + 1) + ((i + 1) % 2));
      else b1.req_valid = 0;
    end
    @(negedge clk);
    checks++;
    if (b1.rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL lat1_end: valid=%b want 0", b1.rsp_valid);
    end
  endtask

  task automatic test_config();
    int lat, low;
    logic [63:0] d, want;
    logic e;
    for (int i = 4; i < 8; i++) begin
      mc[i] = 16'($urandom);
      bc.req_valid = 1; bc.req_we = 1; bc.req_addr = 17'(i); bc.req_wdata = mc[i]; bc.req_wstrb = 2'b11;
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) want[16*k +: 16] = mc[4 + k];
    bc.req_valid = 1; bc.req_we = 0; bc.req_addr = 17'd7;
    lat = -1; low = 0; d = '0; e = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) bc.req_valid = 0;
      if (!bc.req_ready) low++;
      if (bc.rsp_valid) begin
        lat = c; d = bc.rsp_data; e = bc.rsp_err;
        break;
      end
    end
    checks++;
    if (lat !== 5 || low !== 4) begin
      errors++;
      $display("FAIL cfg_latency: lat=%0d ready_low=%0d want 5/4", lat, low);
    end
    checks++;
    if (d !== want || e !== 1'b0) begin
      errors++;
      $display("FAIL cfg_data: data=%h err=%b want %h/0", d, e, want);
    end
  endtask

  initial begin
    all_idle();
    test_reset();
    test_fill();
    test_write_read();
    test_strobes();
    test_out_of_range();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    test_lat1();
    test_config();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
